// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and small op-decoding helpers.
package mdu_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        SIGN = 2'b10
    } state_t;

    // Bit 0 clear marks the signed variants, bit 1 set marks the divides.
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract
// for divide. Purely combinational; the caller registers acc/q each cycle.
module mdu_step #(
    parameter int DATA_W = 32
) (
    input  logic              i_is_div,
    input  logic [DATA_W-1:0] i_acc,
    input  logic [DATA_W-1:0] i_q,
    input  logic [DATA_W-1:0] i_m,
    output logic [DATA_W-1:0] o_acc,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_shift;
    logic [DATA_W+1:0] w_diff;

    always_comb begin
        w_sum   = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_m} : '0);
        w_shift = {i_acc, i_q[DATA_W-1]};
        w_diff  = {1'b0, w_shift} - {2'b00, i_m};
        o_acc   = w_sum[DATA_W:1];
        o_q     = {w_sum[0], i_q[DATA_W-1:1]};
        if (i_is_div) begin
            // A borrow out means the trial subtract went negative: restore.
            if (!w_diff[DATA_W+1]) begin
                o_acc = w_diff[DATA_W-1:0];
                o_q   = {i_q[DATA_W-2:0], 1'b1};
            end else begin
                o_acc = w_shift[DATA_W-1:0];
                o_q   = {i_q[DATA_W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// Optional MTHI/MTLO write ports are added when MDU_MTHILO_EN is defined.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
`ifdef MDU_MTHILO_EN
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] wdata,
`endif
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output state_t            o_dbg_state
);

    localparam int CNT_W = $clog2(DATA_W);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_div;
    logic               r_neg_a;
    logic               r_neg_b;
    logic [DATA_W-1:0]  r_acc;
    logic [DATA_W-1:0]  r_q;
    logic [DATA_W-1:0]  r_m;
    logic               r_busy;
    logic               r_done;
    logic [DATA_W-1:0]  r_hi;
    logic [DATA_W-1:0]  r_lo;

    logic                w_signed;
    logic                w_neg_a;
    logic                w_neg_b;
    logic [DATA_W-1:0]   w_mag_a;
    logic [DATA_W-1:0]   w_mag_b;
    logic [DATA_W-1:0]   w_acc_nxt;
    logic [DATA_W-1:0]   w_q_nxt;
    logic                w_neg_res;
    logic [2*DATA_W-1:0] w_prod;
    logic [2*DATA_W-1:0] w_prod_fix;
    logic [DATA_W-1:0]   w_quo_fix;
    logic [DATA_W-1:0]   w_rem_fix;

    assign w_signed = op_is_signed(op);
    assign w_neg_a  = w_signed & src_a[DATA_W-1];
    assign w_neg_b  = w_signed & src_b[DATA_W-1];
    assign w_mag_a  = w_neg_a ? -src_a : src_a;
    assign w_mag_b  = w_neg_b ? -src_b : src_b;

    mdu_step #(.DATA_W(DATA_W)) u_step (
        .i_is_div (r_is_div),
        .i_acc    (r_acc),
        .i_q      (r_q),
        .i_m      (r_m),
        .o_acc    (w_acc_nxt),
        .o_q      (w_q_nxt)
    );

    // Divide by zero leaves q all ones and acc = |a|; forcing lo and letting
    // the dividend sign fix run makes hi equal the original src_a.
    assign w_neg_res  = r_neg_a ^ r_neg_b;
    assign w_prod     = {r_acc, r_q};
    assign w_prod_fix = w_neg_res ? -w_prod : w_prod;
    assign w_quo_fix  = (r_m == '0) ? '1 : (w_neg_res ? -r_q : r_q);
    assign w_rem_fix  = r_neg_a ? -r_acc : r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_acc    <= '0;
            r_q      <= '0;
            r_m      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_is_div <= op_is_div(op);
                        r_neg_a  <= w_neg_a;
                        r_neg_b  <= w_neg_b;
                        r_acc    <= '0;
                        r_q      <= op_is_div(op) ? w_mag_a : w_mag_b;
                        r_m      <= op_is_div(op) ? w_mag_b : w_mag_a;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= CALC;
                    end
`ifdef MDU_MTHILO_EN
                    else begin
                        if (hi_we) r_hi <= wdata;
                        if (lo_we) r_lo <= wdata;
                    end
`endif
                end
                CALC: begin
                    r_acc <= w_acc_nxt;
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(DATA_W - 1)) r_state <= SIGN;
                end
                SIGN: begin
                    if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*DATA_W-1:DATA_W];
                        r_lo <= w_prod_fix[DATA_W-1:0];
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: scoreboard of {hi,lo} results,
// latency/busy/done checks, start collision, mid-op reset, optional MTHI/MTLO.
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    state_t       dbg_state;
`ifdef MDU_MTHILO_EN
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] wdata = '0;
`endif

    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] last_res;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.DATA_W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
`ifdef MDU_MTHILO_EN
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
`endif
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .o_dbg_state (dbg_state)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference result {hi,lo} from plain 64-bit arithmetic.
    function automatic logic [2*W-1:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (o)
            OP_MULT:  p = sa * sb;
            OP_MULTU: p = {32'b0, a} * {32'b0, b};
            OP_DIV: begin
                if (b == '0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == '0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    // mode: 0 plain, 1 second start at edge N+5, 2 MTHI/MTLO with start, 3 MTHI while busy.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int mode, input bit sync);
        int lat;
        bit seen;
        bit busy_gap;
        bit busy_at_done;
        logic [2*W-1:0] exp;
        if (sync) @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
`ifdef MDU_MTHILO_EN
        if (mode == 2) begin hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0BAD_F00D; end
`endif
        exp_q.push_back(model(o, a, b));
        @(posedge clk); #1;
        check_val("busy_after_start", 64'(busy), 64'd1);
        @(negedge clk);
        start = 1'b0;
`ifdef MDU_MTHILO_EN
        hi_we = 1'b0; lo_we = 1'b0;
`endif
        src_a = $urandom; src_b = $urandom; op = 2'($urandom_range(0, 3));
        lat = 1; seen = 0; busy_gap = 0; busy_at_done = 0;
        while (!seen && lat <= W + 4) begin
            if (mode == 1 && lat == 5) begin
                start = 1'b1; op = OP_MULTU; src_a = 32'h0000_1111; src_b = 32'h0000_2222;
            end
`ifdef MDU_MTHILO_EN
            if (mode == 3 && lat == 3) begin hi_we = 1'b1; wdata = 32'h1234_5678; end
`endif
            @(posedge clk); #1;
            if (done) begin
                seen = 1;
                busy_at_done = busy;
            end else begin
                if (!busy) busy_gap = 1;
                if (lat == 1 || lat == W / 2) check_val("hold_prev", {hi, lo}, last_res);
                lat++;
            end
            @(negedge clk);
            start = 1'b0;
`ifdef MDU_MTHILO_EN
            hi_we = 1'b0; lo_we = 1'b0;
`endif
        end
        exp = exp_q.pop_front();
        if (!seen) begin
            check_val("done_timeout", 64'd0, 64'd1);
        end else begin
            check_val("latency", 64'(lat), 64'(W + 1));
            check_val("busy_at_done", 64'(busy_at_done), 64'd0);
            check_val("busy_continuous", 64'(busy_gap), 64'd0);
            check_val("result", {hi, lo}, exp);
            last_res = exp;
            @(posedge clk); #1;
            check_val("done_one_cycle", 64'(done), 64'd0);
        end
    endtask

    task automatic reset_mid_op();
        int pulses;
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; src_a = $urandom; src_b = $urandom;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_hilo", {hi, lo}, 64'd0);
        check_val("rst_state", 64'(dbg_state), 64'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        last_res = '0;
        pulses = 0;
        repeat (W + 5) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check_val("no_done_after_reset", 64'(pulses), 64'd0);
        check_val("hilo_after_abort", {hi, lo}, 64'd0);
    endtask

    initial begin
        last_res = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("init_busy", 64'(busy), 64'd0);
        check_val("init_done", 64'(done), 64'd0);
        check_val("init_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 0, 0);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 0, 1);
        run_op(OP_DIVU,  32'h0000_0064, 32'h0000_0000, 0, 1);
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 1);
        run_op(OP_DIV,   32'hFFFF_FF9C, 32'h0000_0000, 0, 1);
        run_op(OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 0, 1);
        run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 0, 1);
        run_op(OP_MULT,  32'h0000_0123, 32'hFFFF_F000, 1, 1);
        for (int i = 0; i < 8; i++)
            run_op(2'($urandom_range(0, 3)), $urandom, $urandom, 0, 1);
        reset_mid_op();
        run_op(OP_DIVU, 32'hDEAD_BEEF, 32'h0000_1234, 0, 1);
`ifdef MDU_MTHILO_EN
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'h1234_5678;
        @(posedge clk); #1;
        last_res[2*W-1:W] = 32'h1234_5678;
        check_val("mthi_idle", {hi, lo}, last_res);
        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        last_res = {32'hCAFE_F00D, 32'hCAFE_F00D};
        check_val("mthilo_both", {hi, lo}, last_res);
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        run_op(OP_MULTU, 32'h0000_0003, 32'h0000_0004, 3, 1);
        run_op(OP_DIV,   32'hFFFF_FF00, 32'h0000_0010, 2, 1);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, setting operand and HI/LO width.
REQ-002 SHALL provide port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL provide port start, input, 1 bit: launch request, sampled on the rising edge.
REQ-005 SHALL provide port op, input, 2 bits: operation, 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL provide port src_a, input, DATA_W bits: multiplicand or dividend, taken from register-file read port 1.
REQ-007 SHALL provide port src_b, input, DATA_W bits: multiplier or divisor, taken from register-file read port 2.
REQ-008 SHALL provide port busy, output, 1 bit: operation in progress; the core uses it as the stall request.
REQ-009 SHALL provide port done, output, 1 bit: one-cycle pulse marking HI/LO updated.
REQ-010 SHALL provide port hi, output, DATA_W bits: product upper half or remainder.
REQ-011 SHALL provide port lo, output, DATA_W bits: product lower half or quotient.

Function
REQ-012 SHALL use FSM states IDLE, CALC and SIGN.
REQ-013 In IDLE, start=1 SHALL latch op and both operand magnitudes (plus sign flags for signed ops), clear the iteration counter and enter CALC.
REQ-014 CALC SHALL run exactly DATA_W iterations, one bit per cycle, then enter SIGN.
REQ-015 Multiply SHALL use radix-2 shift-add; divide SHALL use radix-2 restoring shift-subtract.
REQ-016 SIGN SHALL apply two's-complement correction, write hi/lo, pulse done for one cycle and return to IDLE.
REQ-017 Timing: start sampled at edge N -> busy=1 after edge N; hi, lo and done updated at edge N+DATA_W+1; busy=0 from that edge on.
REQ-018 start while busy=1 SHALL be ignored with no effect on the running operation.
REQ-019 hi/lo SHALL hold their values from the previous completion until the next SIGN edge.
REQ-020 Signed multiply: {hi,lo} SHALL equal the exact 2*DATA_W-bit two's-complement product.
REQ-021 Signed divide: quotient SHALL truncate toward zero and remainder SHALL take the dividend's sign.
REQ-022 Divide by zero: lo SHALL be all ones and hi SHALL equal src_a, for both signed and unsigned divide.
REQ-023 Signed divide of most-negative value by -1: lo SHALL be the most-negative value and hi SHALL be 0, with no trap.
REQ-024 Operand inputs SHALL be ignored after the start edge.

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, regardless of clk.
REQ-026 Reset asserted mid-operation SHALL abort it with no done pulse, and no partial result SHALL reach hi/lo.
REQ-027 The first start SHALL be honoured on the first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro MDU_MTHILO_EN SHALL add inputs hi_we (1), lo_we (1) and wdata (DATA_W) implementing MTHI/MTLO.
REQ-029 With MDU_MTHILO_EN defined and in IDLE: hi_we=1 SHALL write wdata to hi and lo_we=1 SHALL write wdata to lo on the edge; both may write in the same cycle.
REQ-030 With MDU_MTHILO_EN defined: writes while busy SHALL be dropped, and start together with hi_we/lo_we SHALL run start and drop the write.
REQ-031 Without MDU_MTHILO_EN, those ports SHALL be absent and hi/lo SHALL change only by reset or completion.

Structure
REQ-032 Shared package mdu_pkg SHALL hold the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and the FSM state typedef.
REQ-033 The per-bit iteration step (add/shift or subtract/restore) SHALL live in sub-module mdu_step; the FSM, counter and sign fix SHALL stay in mult_div_unit.

Verification
REQ-034 MULT src_a=FFFFFFFD (-3), src_b=00000005 -> at edge N+33: hi=FFFFFFFF, lo=FFFFFFF1, done=1 for one cycle.
REQ-035 MULTU FFFFFFFF x FFFFFFFF -> hi=FFFFFFFE, lo=00000001; DIV FFFFFFF9 (-7) / 00000002 -> lo=FFFFFFFD, hi=FFFFFFFF.
REQ-036 DIVU 00000064 / 00000000 -> lo=FFFFFFFF, hi=00000064; DIV 80000000 / FFFFFFFF -> lo=80000000, hi=00000000.
REQ-037 Second start (different operands) at edge N+5 -> ignored; first result unchanged; busy stays continuous 1 until edge N+33.
REQ-038 rst_n pulsed low between edges N+10 and N+11 -> busy=0, hi=lo=0 immediately; no done pulse.
REQ-039 MDU_MTHILO_EN defined: hi_we=1 with wdata=12345678 while IDLE -> hi=12345678; the same write while busy -> hi unchanged.
